demux_buf: RTL and testbench
============================

DEMUX_BUF -- requirements
Module: demux_buf

Interface
REQ-001 Parameter WIDTH, default 16, sets the data width of the input and both output ports.
REQ-002 clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 valid_i, input, 1 bit: the upstream word on d_i is valid.
REQ-005 sel_i, input, 1 bit: destination of the input word (0 = port 0, 1 = port 1).
REQ-006 d_i, input, WIDTH bits: input data word.
REQ-007 ready_o, output, 1 bit: demux_buf accepts the word this cycle if valid_i is also high.
REQ-008 v0_o / v1_o, output, 1 bit each: port 0 / port 1 head word is valid.
REQ-009 d0_o / d1_o, output, WIDTH bits each: port 0 / port 1 head word.
REQ-010 ready0_i / ready1_i, input, 1 bit each: the port 0 / port 1 consumer takes the head word this cycle.
REQ-011 cnt0_o / cnt1_o, output, 8 bits each: count of words accepted for port 0 / port 1.

Function
REQ-012 Each output port SHALL own an independent 2-entry FIFO with occupancy 0..2; v0_o / v1_o = (occupancy != 0).
REQ-013 ready_o SHALL be combinational from sel_i and occupancy only: high iff FIFO[sel_i] occupancy < 2; no path from ready0_i/ready1_i to ready_o.
REQ-014 Enqueue SHALL occur iff valid_i & ready_o: d_i is written to FIFO[sel_i] and cnt[sel_i] increments by 1.
REQ-015 When valid_i is low, sel_i and d_i SHALL be ignored; no state changes from the input side.
REQ-016 Dequeue on port k SHALL occur iff vk_o & readyk_i; readyk_i is ignored while vk_o is low.
REQ-017 A word enqueued at edge N SHALL appear on dk_o no earlier than the cycle after edge N; there is no combinational path from d_i to d0_o/d1_o.
REQ-018 Each port SHALL deliver words in acceptance order; ports never reorder or share entries.
REQ-019 Simultaneous enqueue and dequeue on the same port at occupancy 1: occupancy stays 1, and the new word becomes the head.
REQ-020 At occupancy 2, ready_o for that port SHALL be low even if the port dequeues in the same cycle; occupancy falls to 1.
REQ-021 A dequeue at occupancy 2 SHALL promote the second entry to head on the next cycle.
REQ-022 Activity on one port (enqueue, dequeue, stall) SHALL NOT affect the other port's occupancy, data or counter.
REQ-023 Counters SHALL be 8-bit unsigned and wrap from 255 to 0; dequeues do not change them.
REQ-024 dk_o SHALL hold its value while vk_o is high and readyk_i is low (stable under backpressure).

Reset
REQ-025 While reset is high at a rising edge: both occupancies go to 0, v0_o = v1_o = 0, d0_o = d1_o = 0, and cnt0_o = cnt1_o = 0.
REQ-026 Reset SHALL take priority over any simultaneous enqueue or dequeue; buffered words are discarded and do not reappear after reset.
REQ-027 ready_o SHALL be high in the first cycle after reset deasserts, for either value of sel_i.

Verification
REQ-028 Basic routing: accept 0x1234 with sel_i=0, then 0xBEEF with sel_i=1 -> d0_o=0x1234 and d1_o=0xBEEF one cycle after each acceptance; cnt0_o=1, cnt1_o=1.
REQ-029 Full/backpressure: hold ready0_i=0 and push 0xA, 0xB, 0xC to port 0 -> ready_o low after two acceptances, 0xC not taken, d0_o stays 0xA, cnt0_o=2; then raise ready0_i -> 0xA, 0xB, 0xC delivered in order.
REQ-030 Simultaneous enqueue/dequeue: port 1 at occupancy 1 holding 0x5, ready1_i=1, enqueue 0x6 -> next cycle v1_o=1, d1_o=0x6, occupancy 1.
REQ-031 Independence: port 0 full and stalled, sel_i=1 with valid_i=1 -> ready_o high and port 1 receives words at full rate.
REQ-032 Counter wrap: 256 accepted words to port 0 -> cnt0_o returns to 0 and cnt1_o is unchanged.
REQ-033 Reset mid-operation: both FIFOs hold 2 words, assert reset for one cycle with valid_i=1 -> all outputs 0, no old word is emitted afterwards, and ready_o is high.

Source files
------------

// File: rtl/demux_buf.sv
// One-to-two demultiplexer with a 2-entry FIFO and an 8-bit acceptance counter per output port.
// Input readiness depends only on the selected port's occupancy, never on the downstream readies.

module demux_buf_fifo2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic [7:0]       o_cnt
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  occ_t             r_occ;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [7:0]       r_cnt;

  logic             w_pop;
  logic             w_load_tail;

  // A pop request with nothing buffered is simply ignored.
  assign w_pop       = i_pop && (r_occ != OCC_EMPTY);
  assign w_load_tail = i_push && !w_pop && (r_occ == OCC_ONE);

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ  <= OCC_EMPTY;
      r_head <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_cnt <= r_cnt + 8'd1;
      case (r_occ)
        OCC_EMPTY: begin
          if (i_push) begin
            r_head <= i_data;
            r_occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({i_push, w_pop})
            2'b11:   r_head <= i_data;
            2'b10:   r_occ  <= OCC_TWO;
            2'b01:   r_occ  <= OCC_EMPTY;
            default: r_occ  <= OCC_ONE;
          endcase
        end
        OCC_TWO: begin
          if (w_pop) begin
            r_head <= r_tail;
            r_occ  <= OCC_ONE;
          end
        end
        default: r_occ <= OCC_EMPTY;
      endcase
    end
  end

  // NOTE: the second slot is storage only; it is read solely at OCC_TWO, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_load_tail) r_tail <= i_data;
  end

  assign o_full  = (r_occ == OCC_TWO);
  assign o_valid = (r_occ != OCC_EMPTY);
  assign o_head  = r_head;
  assign o_cnt   = r_cnt;

endmodule

module demux_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             ready_o,
  output logic             v0_o,
  output logic [WIDTH-1:0] d0_o,
  input  logic             ready0_i,
  output logic             v1_o,
  output logic [WIDTH-1:0] d1_o,
  input  logic             ready1_i,
  output logic [7:0]       cnt0_o,
  output logic [7:0]       cnt1_o
);

  logic w_full0;
  logic w_full1;
  logic w_accept;
  logic w_push0;
  logic w_push1;

  // Readiness looks at occupancy only, so a same-cycle dequeue never frees a slot early.
  assign ready_o  = sel_i ? !w_full1 : !w_full0;
  assign w_accept = valid_i && ready_o;
  assign w_push0  = w_accept && !sel_i;
  assign w_push1  = w_accept &&  sel_i;

  demux_buf_fifo2 #(.WIDTH(WIDTH)) u_port0 (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push0),
    .i_data  (d_i),
    .i_pop   (ready0_i),
    .o_full  (w_full0),
    .o_valid (v0_o),
    .o_head  (d0_o),
    .o_cnt   (cnt0_o)
  );

  demux_buf_fifo2 #(.WIDTH(WIDTH)) u_port1 (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push1),
    .i_data  (d_i),
    .i_pop   (ready1_i),
    .o_full  (w_full1),
    .o_valid (v1_o),
    .o_head  (d1_o),
    .o_cnt   (cnt1_o)
  );

endmodule

// File: tb/tb_demux_buf.sv
// Self-checking bench for demux_buf: directed scenarios plus randomized traffic
// compared against a queue-based model of the two output ports.

module tb_demux_buf;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, valid_i, sel_i, ready0_i, ready1_i;
  logic [W-1:0] d_i;
  logic         ready_o, v0_o, v1_o;
  logic [W-1:0] d0_o, d1_o;
  logic [7:0]   cnt0_o, cnt1_o;

  int pass_cnt = 0;
  int total    = 0;

  // Reference model: one queue per port plus acceptance counters.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [7:0]   m_cnt0, m_cnt1;

  always #5 clk = ~clk;

  demux_buf #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .sel_i    (sel_i),
    .d_i      (d_i),
    .ready_o  (ready_o),
    .v0_o     (v0_o),
    .d0_o     (d0_o),
    .ready0_i (ready0_i),
    .v1_o     (v1_o),
    .d1_o     (d1_o),
    .ready1_i (ready1_i),
    .cnt0_o   (cnt0_o),
    .cnt1_o   (cnt1_o)
  );

  // Called just after a falling edge: drive inputs, sample ready_o, clock once, update the model,
  // and return just after the next falling edge.
  task automatic step(input logic rst, input logic v, input logic s, input logic [W-1:0] d,
                      input logic r0, input logic r1, output logic rdy);
    logic acc, dq0, dq1;
    reset = rst; valid_i = v; sel_i = s; d_i = d; ready0_i = r0; ready1_i = r1;
    #1 rdy = ready_o;
    acc = v && ((s ? q1.size() : q0.size()) < 2);
    dq0 = r0 && (q0.size() != 0);
    dq1 = r1 && (q1.size() != 0);
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete(); m_cnt0 = 8'd0; m_cnt1 = 8'd0;
    end else begin
      if (dq0) void'(q0.pop_front());
      if (dq1) void'(q1.pop_front());
      if (acc) begin
        if (s) begin q1.push_back(d); m_cnt1 = m_cnt1 + 8'd1; end
        else   begin q0.push_back(d); m_cnt0 = m_cnt0 + 8'd1; end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    logic rdy;
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, rdy);
  endtask

  task automatic test_reset();
    logic rdy;
    step(1'b1, 1'b1, 1'b0, 16'h5A5A, 1'b1, 1'b1, rdy);
    step(1'b1, 1'b1, 1'b1, 16'hA5A5, 1'b1, 1'b1, rdy);
    total++;
    if ({v0_o, v1_o, d0_o, d1_o, cnt0_o, cnt1_o} !== '0)
      $display("FAIL reset_outputs: v0=%b v1=%b d0=%h d1=%h cnt0=%0d cnt1=%0d, required all 0",
               v0_o, v1_o, d0_o, d1_o, cnt0_o, cnt1_o);
    else pass_cnt++;
    reset = 1'b0; valid_i = 1'b0; sel_i = 1'b0;
    #1 total++;
    if (ready_o !== 1'b1) $display("FAIL reset_ready_sel0: got %b, required 1", ready_o);
    else pass_cnt++;
    sel_i = 1'b1;
    #1 total++;
    if (ready_o !== 1'b1) $display("FAIL reset_ready_sel1: got %b, required 1", ready_o);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_routing();
    logic rdy;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, rdy);
    total++;
    if ({rdy, v0_o, d0_o, v1_o} !== {1'b1, 1'b1, 16'h1234, 1'b0})
      $display("FAIL routing_p0: rdy=%b v0=%b d0=%h v1=%b, required 1 1 1234 0", rdy, v0_o, d0_o, v1_o);
    else pass_cnt++;
    step(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, rdy);
    total++;
    if ({v1_o, d1_o, d0_o, cnt0_o, cnt1_o} !== {1'b1, 16'hBEEF, 16'h1234, 8'd1, 8'd1})
      $display("FAIL routing_p1: v1=%b d1=%h d0=%h cnt0=%0d cnt1=%0d, required 1 beef 1234 1 1",
               v1_o, d1_o, d0_o, cnt0_o, cnt1_o);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, rdy);
    total++;
    if ({v0_o, v1_o, cnt0_o, cnt1_o} !== {1'b0, 1'b0, 8'd1, 8'd1})
      $display("FAIL routing_drain: v0=%b v1=%b cnt0=%0d cnt1=%0d, required 0 0 1 1", v0_o, v1_o, cnt0_o, cnt1_o);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic rdy;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 16'h000A, 1'b0, 1'b0, rdy);
    step(1'b0, 1'b1, 1'b0, 16'h000B, 1'b0, 1'b0, rdy);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h000C, 1'b0, 1'b0, rdy);
      total++;
      if ({rdy, v0_o, d0_o, cnt0_o} !== {1'b0, 1'b1, 16'h000A, 8'd2})
        $display("FAIL bp_stall%0d: rdy=%b v0=%b d0=%h cnt0=%0d, required 0 1 000a 2", i, rdy, v0_o, d0_o, cnt0_o);
      else pass_cnt++;
    end
    step(1'b0, 1'b1, 1'b0, 16'h000C, 1'b1, 1'b0, rdy);
    total++;
    if ({rdy, v0_o, d0_o} !== {1'b0, 1'b1, 16'h000B})
      $display("FAIL bp_deq_full: rdy=%b v0=%b d0=%h, required 0 1 000b", rdy, v0_o, d0_o);
    else pass_cnt++;
    step(1'b0, 1'b1, 1'b0, 16'h000C, 1'b1, 1'b0, rdy);
    total++;
    if ({rdy, v0_o, d0_o, cnt0_o} !== {1'b1, 1'b1, 16'h000C, 8'd3})
      $display("FAIL bp_deliver_c: rdy=%b v0=%b d0=%h cnt0=%0d, required 1 1 000c 3", rdy, v0_o, d0_o, cnt0_o);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, rdy);
    total++;
    if (v0_o !== 1'b0) $display("FAIL bp_empty: v0=%b, required 0", v0_o);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic rdy;
    do_reset();
    step(1'b0, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, rdy);
    step(1'b0, 1'b1, 1'b1, 16'h0006, 1'b0, 1'b1, rdy);
    total++;
    if ({rdy, v1_o, d1_o} !== {1'b1, 1'b1, 16'h0006})
      $display("FAIL simul_enq_deq: rdy=%b v1=%b d1=%h, required 1 1 0006", rdy, v1_o, d1_o);
    else pass_cnt++;
    step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, rdy);
    total++;
    if (v1_o !== 1'b0) $display("FAIL simul_occ_one: v1=%b, required 0 after single dequeue", v1_o);
    else pass_cnt++;
  endtask

  task automatic test_independence();
    logic rdy;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 16'h0111, 1'b0, 1'b0, rdy);
    step(1'b0, 1'b1, 1'b0, 16'h0222, 1'b0, 1'b0, rdy);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b1, rdy);
      total++;
      if ({rdy, v1_o, d1_o, v0_o, d0_o} !== {1'b1, 1'b1, 16'h0100 + 16'(i), 1'b1, 16'h0111})
        $display("FAIL indep%0d: rdy=%b v1=%b d1=%h v0=%b d0=%h, required 1 1 %h 1 0111",
                 i, rdy, v1_o, d1_o, v0_o, d0_o, 16'h0100 + 16'(i));
      else pass_cnt++;
    end
    total++;
    if ({cnt0_o, cnt1_o} !== {8'd2, 8'd6})
      $display("FAIL indep_counts: cnt0=%0d cnt1=%0d, required 2 6", cnt0_o, cnt1_o);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic rdy;
    logic all_rdy;
    do_reset();
    step(1'b0, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, rdy);
    all_rdy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'(i), 1'b1, 1'b0, rdy);
      all_rdy &= rdy;
      if (i == 254) begin
        total++;
        if (cnt0_o !== 8'd255) $display("FAIL wrap_255: cnt0=%0d, required 255", cnt0_o);
        else pass_cnt++;
      end
    end
    total++;
    if ({all_rdy, cnt0_o, cnt1_o, d0_o} !== {1'b1, 8'd0, 8'd1, 16'd255})
      $display("FAIL wrap_0: all_rdy=%b cnt0=%0d cnt1=%0d d0=%h, required 1 0 1 00ff", all_rdy, cnt0_o, cnt1_o, d0_o);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic rdy, exp_rdy, rst, v, s, r0, r1;
    logic [W-1:0] d;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      s   = 1'($urandom);
      d   = W'($urandom);
      r0  = ($urandom_range(0, 2) == 0);
      r1  = ($urandom_range(0, 2) != 0);
      exp_rdy = (s ? q1.size() : q0.size()) < 2;
      step(rst, v, s, d, r0, r1, rdy);
      total++;
      if (rdy !== exp_rdy) $display("FAIL rand_ready@%0d: got %b, required %b", i, rdy, exp_rdy);
      else pass_cnt++;
      total++;
      if ({v0_o, v1_o, cnt0_o, cnt1_o} !== {q0.size() != 0, q1.size() != 0, m_cnt0, m_cnt1})
        $display("FAIL rand_state@%0d: v0=%b v1=%b cnt0=%0d cnt1=%0d, required %b %b %0d %0d", i,
                 v0_o, v1_o, cnt0_o, cnt1_o, q0.size() != 0, q1.size() != 0, m_cnt0, m_cnt1);
      else pass_cnt++;
      if (q0.size() != 0) begin
        total++;
        if (d0_o !== q0[0]) $display("FAIL rand_d0@%0d: got %h, required %h", i, d0_o, q0[0]);
        else pass_cnt++;
      end
      if (q1.size() != 0) begin
        total++;
        if (d1_o !== q1[0]) $display("FAIL rand_d1@%0d: got %h, required %h", i, d1_o, q1[0]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic rdy;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0, rdy);
    step(1'b0, 1'b1, 1'b0, 16'h0022, 1'b0, 1'b0, rdy);
    step(1'b0, 1'b1, 1'b1, 16'h0033, 1'b0, 1'b0, rdy);
    step(1'b0, 1'b1, 1'b1, 16'h0044, 1'b0, 1'b0, rdy);
    step(1'b1, 1'b1, 1'b0, 16'h0055, 1'b1, 1'b1, rdy);
    total++;
    if ({v0_o, v1_o, d0_o, d1_o, cnt0_o, cnt1_o} !== '0)
      $display("FAIL midreset_outputs: v0=%b v1=%b d0=%h d1=%h cnt0=%0d cnt1=%0d, required all 0",
               v0_o, v1_o, d0_o, d1_o, cnt0_o, cnt1_o);
    else pass_cnt++;
    reset = 1'b0; valid_i = 1'b0; sel_i = 1'b0;
    #1 total++;
    if (ready_o !== 1'b1) $display("FAIL midreset_ready0: got %b, required 1", ready_o);
    else pass_cnt++;
    sel_i = 1'b1;
    #1 total++;
    if (ready_o !== 1'b1) $display("FAIL midreset_ready1: got %b, required 1", ready_o);
    else pass_cnt++;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, rdy);
      total++;
      if ({v0_o, v1_o} !== 2'b00) $display("FAIL midreset_ghost%0d: v0=%b v1=%b, required 0 0", i, v0_o, v1_o);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; sel_i = 1'b0; d_i = '0; ready0_i = 1'b0; ready1_i = 1'b0;
    m_cnt0 = 8'd0; m_cnt1 = 8'd0;
    @(negedge clk);
    test_reset();
    test_routing();
    test_backpressure();
    test_simultaneous();
    test_independence();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
